// File: rtl/dz_countdown.sv
// Countdown sequencer for the dot-matrix digit display: one-second prescaler,
// START_VAL..0 countdown with start/restart and pause/resume buttons.
// Optional `DZ_COUNTDOWN_AUTORELOAD_EN: DONE waits one tick period, then reloads.
module dz_countdown #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int START_VAL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] num,
  output logic [1:0] color,
  output logic       running,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST     = PW'(TICK_DIV - 1);
  localparam logic [2:0]    LOAD_NUM = 3'(START_VAL);

  logic [1:0]    state, state_nxt;
  logic [2:0]    num_nxt;
  logic [1:0]    color_nxt;
  logic [PW-1:0] prescaler, prescaler_nxt;
  logic          done_nxt;
  logic          start_prev, pause_prev;
  logic          start_edge, pause_edge, period_end;

  assign start_edge = start & ~start_prev;
  assign pause_edge = pause & ~pause_prev;
  assign period_end = (prescaler == LAST);

  // NOTE: next-state logic uses blocking defaults first, so every path assigns
  // every output and no latch is inferred; the registers below use <= only.
  always_comb begin
    state_nxt     = state;
    num_nxt       = num;
    color_nxt     = color;
    prescaler_nxt = prescaler;
    done_nxt      = 1'b0;
    if (start_edge) begin
      // Load beats both a coincident tick and a coincident pause edge.
      state_nxt     = RUN;
      num_nxt       = LOAD_NUM;
      color_nxt     = 2'd0;
      prescaler_nxt = '0;
    end else begin
      case (state)
        RUN: begin
          prescaler_nxt = period_end ? '0 : prescaler + PW'(1);
          if (period_end && num != 3'd0) begin
            num_nxt   = num - 3'd1;
            color_nxt = (color == 2'd2) ? 2'd0 : color + 2'd1;
          end
          if (period_end && num == 3'd1) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else if (pause_edge) begin
            // The edge cycle still counts as RUN time; freezing starts after it.
            state_nxt = PAUSE;
          end
        end
        PAUSE: begin
          if (pause_edge) state_nxt = RUN;
        end
        DONE: begin
`ifdef DZ_COUNTDOWN_AUTORELOAD_EN
          prescaler_nxt = period_end ? '0 : prescaler + PW'(1);
          if (period_end) begin
            state_nxt = RUN;
            num_nxt   = LOAD_NUM;
            color_nxt = 2'd0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: edge-detect history resets to 1 so a button held through reset
  // cannot fire; every other register resets to its idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      num        <= 3'd0;
      color      <= 2'd0;
      prescaler  <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      state      <= state_nxt;
      num        <= num_nxt;
      color      <= color_nxt;
      prescaler  <= prescaler_nxt;
      running    <= (state_nxt == RUN);
      done       <= done_nxt;
      start_prev <= start;
      pause_prev <= pause;
    end
  end

endmodule

// File: tb/tb_dz_countdown.sv
// Self-checking bench for dz_countdown with TICK_DIV=4, START_VAL=5.
// A vector table covers reset and one full countdown; directed sequences cover pause, priority and reset cases.
module tb_dz_countdown;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [2:0] num;
  logic [1:0] color;
  logic       running, done;

  int checks = 0;
  int errors = 0;

  dz_countdown #(.TICK_DIV(4), .START_VAL(5)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .num(num), .color(color), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       start;
    bit       pause;
    bit [2:0] num;
    bit [1:0] color;
    bit       running;
    bit       done;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(bit r, bit s, bit p, bit [2:0] n, bit [1:0] c, bit run, bit d);
    vec_t v;
    v.rst = r; v.start = s; v.pause = p;
    v.num = n; v.color = c; v.running = run; v.done = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit [2:0] n, input bit [1:0] c,
                           input bit run, input bit d);
    check({tag, ".num"}, 8'(num), 8'(n));
    check({tag, ".color"}, 8'(color), 8'(c));
    check({tag, ".running"}, 8'(running), 8'(run));
    check({tag, ".done"}, 8'(done), 8'(d));
  endtask

  // Drive inputs at the falling edge, let one rising edge act, sample at the next falling edge.
  task automatic step(input bit r, input bit s, input bit p);
    rst = r; start = s; pause = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0;

    //           rst st ps num col run done
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 5, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 5, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 5, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 5, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 4, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 4, 1, 1, 0);
    vecs[8]  = mk(0, 0, 0, 4, 1, 1, 0);
    vecs[9]  = mk(0, 0, 0, 4, 1, 1, 0);
    vecs[10] = mk(0, 0, 0, 3, 2, 1, 0);
    vecs[11] = mk(0, 0, 0, 3, 2, 1, 0);
    vecs[12] = mk(0, 0, 0, 3, 2, 1, 0);
    vecs[13] = mk(0, 0, 0, 3, 2, 1, 0);
    vecs[14] = mk(0, 0, 0, 2, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 2, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 2, 0, 1, 0);
    vecs[17] = mk(0, 0, 0, 2, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 1, 1, 1, 0);
    vecs[19] = mk(0, 0, 0, 1, 1, 1, 0);
    vecs[20] = mk(0, 0, 0, 1, 1, 1, 0);
    vecs[21] = mk(0, 0, 0, 1, 1, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 2, 0, 1);
    vecs[23] = mk(0, 0, 0, 0, 2, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 2, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 2, 0, 0);

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].pause);
      check_out($sformatf("vec%0d", i), vecs[i].num, vecs[i].color, vecs[i].running, vecs[i].done);
    end

`ifdef DZ_COUNTDOWN_AUTORELOAD_EN
    // Fourth cycle after done: automatic reload.
    step(0, 0, 0);
    check_out("autoreload", 5, 0, 1, 0);
`else
    // DONE is terminal; pause edges are ignored there.
    for (int i = 0; i < 50; i++) begin
      step(0, 0, (i % 6) == 2);
      check($sformatf("done_hold%0d.num", i), 8'(num), 8'd0);
      check($sformatf("done_hold%0d.running", i), 8'(running), 8'd0);
      check($sformatf("done_hold%0d.done", i), 8'(done), 8'd0);
    end
`endif

    // Pause two cycles into the num=3 period, hold, resume: 2 RUN cycles remain.
    step(0, 1, 0);
    check_out("reload", 5, 0, 1, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 0);
    check_out("num3_start", 3, 2, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    check_out("pause_enter", 3, 2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, i < 3);
      check($sformatf("pause_hold%0d.num", i), 8'(num), 8'd3);
      check($sformatf("pause_hold%0d.running", i), 8'(running), 8'd0);
    end
    step(0, 0, 1);
    check_out("resume", 3, 2, 1, 0);
    step(0, 0, 0);
    check_out("resume_p1", 3, 2, 1, 0);
    step(0, 0, 0);
    check_out("resume_dec", 2, 0, 1, 0);

    // Start and pause edges together: load wins, pause discarded.
    step(0, 1, 1);
    check_out("start_and_pause", 5, 0, 1, 0);
    step(0, 0, 0);
    check_out("no_pause_taken", 5, 0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_out("first_dec_after_sp", 4, 1, 1, 0);

    // Start edge on a tick cycle: load, no decrement, no done.
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    check_out("start_on_tick", 5, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check_out("tick_load_hold", 5, 0, 1, 0);
    step(0, 0, 0);
    check_out("tick_load_dec", 4, 1, 1, 0);

    // Reset mid-count at num=2, then pause edges in IDLE are ignored.
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    check_out("before_rst", 2, 0, 1, 0);
    step(1, 0, 0);
    check_out("rst_mid", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, i[0]);
      check_out($sformatf("idle_pause%0d", i), 0, 0, 0, 0);
    end

    // Start held through reset release does not fire; a later rising edge does.
    step(1, 1, 0);
    step(0, 1, 0);
    check_out("held_start_a", 0, 0, 0, 0);
    step(0, 1, 0);
    check_out("held_start_b", 0, 0, 0, 0);
    step(0, 0, 0);
    check_out("held_start_low", 0, 0, 0, 0);
    step(0, 1, 0);
    check_out("late_start", 5, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
